ysyx_25040109_trap_seq: RTL and testbench
=========================================

# ysyx_25040109_trap_seq

Trap/return sequencer for the single-issue NPC core. It owns the one write port of the CSR bank inside the register file and turns an `ecall`/exception or an `mret` into an ordered series of single-port CSR writes, followed by a one-cycle PC redirect. Normal `csrrw`/`csrrs` writes from the execute stage pass through it while it is idle. While it is sequencing, it stalls the core.

## Interface
- `DATA_WIDTH`, default 32: CSR and PC width.
- `clock`  in  1: the single clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high; sampled on posedge `clock`.
- `trap_req`  in  1: the exception/`ecall` commit point; a one-cycle request.
- `trap_pc`  in  DATA_WIDTH: PC of the trapping instruction.
- `trap_cause`  in  DATA_WIDTH: mcause value (11 for M-mode `ecall`).
- `mret_req`  in  1: `mret` commit; a one-cycle request.
- `core_csr_we` / `core_csr_addr` / `core_csr_wdata`  in  1 / 12 / DATA_WIDTH: CSR write from execute.
- `csr_rdata`  in  DATA_WIDTH: combinational CSR read data, which follows `csr_addr`.
- `mtvec_in`, `mepc_in`  in  DATA_WIDTH: registered mtvec/mepc values from the CSR bank.
- `csr_we` / `csr_addr` / `csr_wdata`  out  1 / 12 / DATA_WIDTH: drive the CSR bank write port.
- `busy`  out  1: stall to the fetch and execute stages.
- `redirect_valid`  out  1: one-cycle PC redirect strobe.
- `redirect_pc`  out  DATA_WIDTH: redirect target; valid only when `redirect_valid` is high.

## Operation
- **States:** IDLE, T_MEPC, T_MCAUSE, T_MSTAT, R_MSTAT, REDIR.
- **IDLE, request acceptance:**
  - `trap_req` is accepted first. It latches `trap_pc` and `trap_cause`, sets an internal `is_mret`=0 and moves to T_MEPC.
  - Otherwise `mret_req` is accepted. It sets `is_mret`=1 and moves to R_MSTAT.
  - If both requests are high in the same cycle, the trap wins and `mret_req` is dropped.
- **IDLE, pass-through:**
  - If there is no request, `csr_we/addr/wdata` = `core_*`, combinationally.
  - If a request is accepted, `csr_we`=0 in that cycle. The trapping instruction's CSR write is discarded.
- **T_MEPC:** `csr_we`=1, addr 0x341, wdata = latched pc with bits [1:0] cleared. Next state T_MCAUSE.
- **T_MCAUSE:** `csr_we`=1, addr 0x342, wdata = latched cause. Next state T_MSTAT.
- **T_MSTAT:**
  - `csr_we`=1, addr 0x300, wdata = `csr_rdata` with MPIE(7) ← MIE(3), MIE ← 0, MPP[12:11] ← 2'b11.
  - All other bits pass unchanged.
  - Next state REDIR.
- **R_MSTAT:**
  - `csr_we`=1, addr 0x300, wdata = `csr_rdata` with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11. The core is M-mode only.
  - Next state REDIR.
- **REDIR:**
  - `redirect_valid`=1 and `csr_we`=0.
  - `redirect_pc` = `{mtvec_in[31:2],2'b00}` for a trap (direct mode only; the mode bits are ignored), or `{mepc_in[31:2],2'b00}` for `mret`.
  - Next state IDLE.
- **Requests while busy:** `trap_req`, `mret_req` and `core_csr_we` are ignored in every non-IDLE state. The core is stalled, so such requests are not legal.
- **`busy`:** equals (state≠IDLE) | `trap_req` | `mret_req`. It is combinational, so the requesting instruction stalls in its commit cycle.
- **`csr_addr` when idle:** when `csr_we`=0 in IDLE, `csr_addr` = `core_csr_addr`. This keeps CSR reads by the core working.

## Timing
- **Trap:** accept in cycle 0; mepc is written at posedge 2, mcause at posedge 3, mstatus at posedge 4; `redirect_valid` is high in cycle 4; IDLE in cycle 5. Total latency is 4 cycles from accept to redirect.
- **`mret`:** accept in cycle 0; mstatus is written at posedge 2; `redirect_valid` is high in cycle 2; IDLE in cycle 3.
- **Back-to-back:** a new request is accepted in the first IDLE cycle after REDIR.
- **Reset:**
  - The state returns to IDLE on the next posedge from any state.
  - A partially sequenced trap is abandoned, with no redirect and no further writes.
  - All latched values are cleared to 0.
  - `csr_we`, `redirect_valid` and `busy` are 0 while `reset` is high. `redirect_pc` is 0 and `csr_addr` follows the core.
- **Read-modify-write of mstatus:** this relies on `csr_rdata` being a combinational function of `csr_addr` and the current register value. It is a same-cycle read-modify-write with no combinational loop.

## Structure
- **Shared package `ysyx_25040109_csr_pkg`:**
  - CSR address constants: MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
  - mstatus bit positions: MIE 3, MPIE 7, MPP 12:11.
  - The trap-sequencer state enum.
  - The cause constant `CAUSE_ECALL_M`=11.
- **No sub-module:**
  - A one-process FSM with registered state and latches.
  - One combinational output process.
  - The mstatus update functions live in the package.

## Test plan
- **Trap:** after reset, mstatus=0x1808 (MIE=1), mtvec_in=0x80001003. Pulse `trap_req` with pc=0x80000104, cause=11 → writes 0x341←0x80000104, then 0x342←0xB, then 0x300←0x1880 on successive cycles; `redirect_pc`=0x80001000 in cycle 4; `busy` high in cycles 0-4.
- **`mret`:** mstatus=0x1880, mepc_in=0x80000104 → 0x300←0x1888; `redirect_valid` in cycle 2 with `redirect_pc`=0x80000104.
- **Simultaneous `trap_req` and `mret_req`:** only the trap sequence runs; exactly one redirect, to the mtvec target.
- **Pass-through:** idle `core_csr_we`=1, addr=0x305, wdata=0x80002000 → same-cycle write on `csr_*`. The same stimulus together with `trap_req` → no 0x305 write occurs.
- **Reset mid-operation:** assert `reset` during T_MCAUSE → no 0x300 write, no redirect, state IDLE; the next trap runs the full sequence.
- **Requests while busy:** `mret_req` and `core_csr_we` pulsed during T_MEPC are ignored; the write sequence is unchanged.

Source files
------------

// File: rtl/ysyx_25040109_csr_pkg.sv
// Shared CSR definitions for the NPC core: addresses, mstatus bit positions,
// the trap-sequencer state type and the mstatus update helpers.
package ysyx_25040109_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  // Only the low bits up to MPP are touched by trap entry/return.
  localparam int MSTATUS_LO_W   = MSTATUS_MPP_HI + 1;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  typedef enum logic [2:0] {
    TS_IDLE,
    TS_T_MEPC,
    TS_T_MCAUSE,
    TS_T_MSTAT,
    TS_R_MSTAT,
    TS_REDIR
  } trap_state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode as previous mode.
  function automatic logic [MSTATUS_LO_W-1:0] mstatus_trap_lo(input logic [MSTATUS_LO_W-1:0] m);
    logic [MSTATUS_LO_W-1:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, previous mode stays M (M-only core).
  function automatic logic [MSTATUS_LO_W-1:0] mstatus_mret_lo(input logic [MSTATUS_LO_W-1:0] m);
    logic [MSTATUS_LO_W-1:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_25040109_trap_seq.sv
// Trap/return sequencer: owns the single CSR write port and serialises the
// mepc/mcause/mstatus updates of a trap (or the mstatus update of an mret),
// then issues a one-cycle PC redirect. Core CSR writes pass through when idle.
module ysyx_25040109_trap_seq
  import ysyx_25040109_csr_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  trap_req,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic                  mret_req,
  input  logic                  core_csr_we,
  input  logic [11:0]           core_csr_addr,
  input  logic [DATA_WIDTH-1:0] core_csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  input  logic [DATA_WIDTH-1:0] mepc_in,
  output logic                  csr_we,
  output logic [11:0]           csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  busy,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  // Clears the two low bits of a PC/vector; mtvec mode bits are ignored (direct mode only).
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

  trap_state_e           state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] cause_q;
  logic                  is_mret_q;

  // Sequencer state and request latches; trap has priority over mret.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= TS_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      is_mret_q <= 1'b0;
    end else begin
      case (state_q)
        TS_IDLE: begin
          if (trap_req) begin
            pc_q      <= trap_pc;
            cause_q   <= trap_cause;
            is_mret_q <= 1'b0;
            state_q   <= TS_T_MEPC;
          end else if (mret_req) begin
            is_mret_q <= 1'b1;
            state_q   <= TS_R_MSTAT;
          end
        end
        TS_T_MEPC:   state_q <= TS_T_MCAUSE;
        TS_T_MCAUSE: state_q <= TS_T_MSTAT;
        TS_T_MSTAT:  state_q <= TS_REDIR;
        TS_R_MSTAT:  state_q <= TS_REDIR;
        TS_REDIR:    state_q <= TS_IDLE;
        default:     state_q <= TS_IDLE;
      endcase
    end
  end

  // CSR port mux, stall and redirect; mstatus is a same-cycle read-modify-write.
  always_comb begin
    csr_we         = 1'b0;
    csr_addr       = core_csr_addr;
    csr_wdata      = core_csr_wdata;
    busy           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (!reset) begin
      busy = (state_q != TS_IDLE) | trap_req | mret_req;
      case (state_q)
        TS_IDLE: begin
          // An accepted request discards the committing instruction's CSR write.
          csr_we = core_csr_we & ~trap_req & ~mret_req;
        end
        TS_T_MEPC: begin
          csr_we    = 1'b1;
          csr_addr  = CSR_MEPC;
          csr_wdata = pc_q & ALIGN_MASK;
        end
        TS_T_MCAUSE: begin
          csr_we    = 1'b1;
          csr_addr  = CSR_MCAUSE;
          csr_wdata = cause_q;
        end
        TS_T_MSTAT: begin
          csr_we    = 1'b1;
          csr_addr  = CSR_MSTATUS;
          csr_wdata = {csr_rdata[DATA_WIDTH-1:MSTATUS_LO_W],
                       mstatus_trap_lo(csr_rdata[MSTATUS_LO_W-1:0])};
        end
        TS_R_MSTAT: begin
          csr_we    = 1'b1;
          csr_addr  = CSR_MSTATUS;
          csr_wdata = {csr_rdata[DATA_WIDTH-1:MSTATUS_LO_W],
                       mstatus_mret_lo(csr_rdata[MSTATUS_LO_W-1:0])};
        end
        TS_REDIR: begin
          redirect_valid = 1'b1;
          redirect_pc    = is_mret_q ? (mepc_in & ALIGN_MASK) : (mtvec_in & ALIGN_MASK);
        end
        default: begin
          csr_we = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040109_trap_seq.sv
// Self-checking bench for the trap/return sequencer. The bench owns a small
// CSR bank (combinational read, posedge write) and a reference model of the
// architectural CSR state; every cycle of every operation is compared.
module tb_ysyx_25040109_trap_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        trap_req = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic        mret_req = 1'b0;
  logic        core_csr_we = 1'b0;
  logic [11:0] core_csr_addr = '0;
  logic [31:0] core_csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec_in, mepc_in;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  int n_vec = 0;
  int n_err = 0;

  // CSR bank seen by the DUT
  logic [31:0] bk_mstatus = 32'h1808, bk_mtvec = 32'h8000_1003;
  logic [31:0] bk_mepc = '0, bk_mcause = '0, bk_mscratch = '0;

  // Reference model of what the bank must hold
  logic [31:0] md_mstatus = 32'h1808, md_mtvec = 32'h8000_1003;
  logic [31:0] md_mepc = '0, md_mcause = '0, md_mscratch = '0;

  ysyx_25040109_trap_seq #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
    .mret_req(mret_req),
    .core_csr_we(core_csr_we), .core_csr_addr(core_csr_addr), .core_csr_wdata(core_csr_wdata),
    .csr_rdata(csr_rdata), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = bk_mstatus;
      12'h305: csr_rdata = bk_mtvec;
      12'h340: csr_rdata = bk_mscratch;
      12'h341: csr_rdata = bk_mepc;
      12'h342: csr_rdata = bk_mcause;
      default: csr_rdata = 32'h0;
    endcase
  end
  assign mtvec_in = bk_mtvec;
  assign mepc_in  = bk_mepc;

  always @(posedge clock) begin
    if (csr_we) begin
      case (csr_addr)
        12'h300: bk_mstatus  <= csr_wdata;
        12'h305: bk_mtvec    <= csr_wdata;
        12'h340: bk_mscratch <= csr_wdata;
        12'h341: bk_mepc     <= csr_wdata;
        12'h342: bk_mcause   <= csr_wdata;
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural mstatus effects of trap entry and of mret
  function automatic logic [31:0] ref_trap_ms(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (m[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction
  function automatic logic [31:0] ref_mret_ms(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (m[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
  endfunction

  task automatic drive_slot();
    @(posedge clock);
    #1;
  endtask

  // Observe one cycle at the falling edge. Address is checked whenever a write
  // is expected or the sequencer should be idle (then it follows the core).
  task automatic obs(input string tag, input logic we, input logic [11:0] addr,
                     input logic [31:0] wd, input logic bsy, input logic rv,
                     input logic [31:0] rpc);
    @(negedge clock);
    chk({tag, ".we"},   {31'b0, csr_we}, {31'b0, we});
    chk({tag, ".busy"}, {31'b0, busy}, {31'b0, bsy});
    chk({tag, ".rv"},   {31'b0, redirect_valid}, {31'b0, rv});
    if (we || !bsy) chk({tag, ".addr"}, {20'b0, csr_addr}, {20'b0, addr});
    if (we) chk({tag, ".wdata"}, csr_wdata, wd);
    if (rv) chk({tag, ".rpc"}, redirect_pc, rpc);
  endtask

  task automatic chk_bank(input string tag);
    chk({tag, ".mstatus"}, bk_mstatus, md_mstatus);
    chk({tag, ".mepc"},    bk_mepc,    md_mepc);
    chk({tag, ".mcause"},  bk_mcause,  md_mcause);
    chk({tag, ".mtvec"},   bk_mtvec,   md_mtvec);
  endtask

  // Full trap; optionally with simultaneous mret, a same-cycle core write,
  // and illegal requests injected while busy.
  task automatic run_trap(input logic [31:0] pc, input logic [31:0] cause,
                          input logic with_mret, input logic with_core, input logic noise);
    logic [31:0] exp_ms;
    drive_slot();
    trap_req = 1'b1; mret_req = with_mret; trap_pc = pc; trap_cause = cause;
    core_csr_we = with_core; core_csr_addr = 12'h305; core_csr_wdata = $urandom;
    obs("trap.c0", 1'b0, 12'h305, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_slot();
    trap_req = 1'b0; mret_req = noise; core_csr_we = noise;
    trap_pc = $urandom; trap_cause = $urandom;
    obs("trap.mepc", 1'b1, 12'h341, pc & ~32'h3, 1'b1, 1'b0, 32'h0);
    drive_slot();
    mret_req = 1'b0; core_csr_we = 1'b0;
    obs("trap.mcause", 1'b1, 12'h342, cause, 1'b1, 1'b0, 32'h0);
    exp_ms = ref_trap_ms(md_mstatus);
    drive_slot();
    obs("trap.mstatus", 1'b1, 12'h300, exp_ms, 1'b1, 1'b0, 32'h0);
    drive_slot();
    obs("trap.redir", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, md_mtvec & ~32'h3);
    md_mepc = pc & ~32'h3; md_mcause = cause; md_mstatus = exp_ms;
    chk_bank("trap.bank");
    $display("op trap pc=0x%08h cause=0x%08h mret=%0b core=%0b noise=%0b", pc, cause, with_mret, with_core, noise);
  endtask

  task automatic run_mret();
    logic [31:0] exp_ms;
    exp_ms = ref_mret_ms(md_mstatus);
    drive_slot();
    mret_req = 1'b1; core_csr_we = $urandom_range(0, 1); core_csr_addr = 12'h340;
    core_csr_wdata = $urandom;
    obs("mret.c0", 1'b0, 12'h340, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_slot();
    mret_req = 1'b0; core_csr_we = 1'b0;
    obs("mret.mstatus", 1'b1, 12'h300, exp_ms, 1'b1, 1'b0, 32'h0);
    drive_slot();
    obs("mret.redir", 1'b0, 12'h0, 32'h0, 1'b1, 1'b1, md_mepc & ~32'h3);
    md_mstatus = exp_ms;
    chk_bank("mret.bank");
    $display("op mret mstatus->0x%08h", exp_ms);
  endtask

  task automatic run_pass(input logic we, input logic [11:0] addr, input logic [31:0] wd);
    drive_slot();
    core_csr_we = we; core_csr_addr = addr; core_csr_wdata = wd;
    obs("pass", we, addr, wd, 1'b0, 1'b0, 32'h0);
    if (we) begin
      case (addr)
        12'h300: md_mstatus  = wd;
        12'h305: md_mtvec    = wd;
        12'h340: md_mscratch = wd;
        12'h341: md_mepc     = wd;
        12'h342: md_mcause   = wd;
        default: ;
      endcase
    end
    $display("op pass we=%0b addr=0x%03h data=0x%08h", we, addr, wd);
  endtask

  // Reset during T_MCAUSE: mepc already written, nothing else, no redirect.
  task automatic run_reset_mid(input logic [31:0] pc);
    drive_slot();
    trap_req = 1'b1; trap_pc = pc; trap_cause = 32'd11; core_csr_we = 1'b0;
    obs("rst.c0", 1'b0, core_csr_addr, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_slot();
    trap_req = 1'b0;
    obs("rst.mepc", 1'b1, 12'h341, pc & ~32'h3, 1'b1, 1'b0, 32'h0);
    drive_slot();
    reset = 1'b1; core_csr_we = 1'b1; core_csr_addr = 12'h342; core_csr_wdata = 32'hDEAD_BEEF;
    obs("rst.hold", 1'b0, 12'h342, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst.rpc", redirect_pc, 32'h0);
    drive_slot();
    reset = 1'b0; core_csr_we = 1'b0;
    obs("rst.idle1", 1'b0, 12'h342, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_slot();
    obs("rst.idle2", 1'b0, 12'h342, 32'h0, 1'b0, 1'b0, 32'h0);
    md_mepc = pc & ~32'h3;
    chk_bank("rst.bank");
    $display("op reset-mid-trap pc=0x%08h", pc);
  endtask

  initial begin
    logic [11:0] pass_addrs [5];
    pass_addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
    core_csr_addr = 12'h123;
    obs("reset", 1'b0, 12'h123, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_slot();
    trap_req = 1'b1; mret_req = 1'b1;
    obs("reset.req", 1'b0, 12'h123, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("reset.rpc", redirect_pc, 32'h0);
    drive_slot();
    trap_req = 1'b0; mret_req = 1'b0; reset = 1'b0;
    obs("idle", 1'b0, 12'h123, 32'h0, 1'b0, 1'b0, 32'h0);

    // Directed scenarios
    run_trap(32'h8000_0104, 32'd11, 1'b0, 1'b0, 1'b0);
    chk("dir.trap_ms", bk_mstatus, 32'h1880);
    run_mret();
    chk("dir.mret_ms", bk_mstatus, 32'h1888);
    run_trap(32'h8000_0200, 32'd2, 1'b1, 1'b0, 1'b0);
    run_pass(1'b1, 12'h305, 32'h8000_2000);
    run_trap(32'h8000_0300, 32'd11, 1'b0, 1'b1, 1'b0);
    run_trap(32'h8000_0403, 32'd5, 1'b0, 1'b0, 1'b1);
    run_reset_mid(32'h8000_0510);
    run_trap(32'h8000_0600, 32'd11, 1'b0, 1'b0, 1'b0);

    // Randomised mix, back-to-back where the dice say so
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0, 1: run_pass(1'($urandom_range(0, 1)), pass_addrs[$urandom_range(0, 4)], $urandom);
        2: run_trap($urandom, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        3: run_mret();
        4: run_reset_mid($urandom);
        default: begin
          drive_slot();
          core_csr_we = 1'b0; core_csr_addr = 12'h300;
          obs("idle.r", 1'b0, 12'h300, 32'h0, 1'b0, 1'b0, 32'h0);
        end
      endcase
    end
    drive_slot();
    core_csr_we = 1'b0;
    chk_bank("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
